// File: rtl/imm_extender.sv
// Immediate extender with a two-entry (output + skid) valid/ready buffer.
// Define IMMEXT_BYTE_MODES_EN to enable modes 4 (BYTE_SIGN) and 5 (BYTE_ZERO).
module imm_extender #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [15:0]      xfer_count
);

`ifdef IMMEXT_BYTE_MODES_EN
    localparam bit ByteModes = 1'b1;
`else
    localparam bit ByteModes = 1'b0;
`endif

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             in_xfer, out_xfer;

    assign sign_ext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            3'd0: ext_data = sign_ext;
            3'd1: ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
            3'd2: ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
            3'd3: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
            3'd4: begin
                if (ByteModes) ext_data = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
                else           ext_err  = 1'b1;
            end
            3'd5: begin
                if (ByteModes) ext_data = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
                else           ext_err  = 1'b1;
            end
            default: ext_err = 1'b1;
        endcase
    end

    // Ready depends only on registered state, never on out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        cnt_d       = out_xfer ? cnt_q + 16'd1 : cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_data_d = ext_data;
                    out_err_d  = ext_err;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    out_data_d = ext_data;
                    out_err_d  = ext_err;
                end else if (in_xfer) begin
                    skid_data_d = ext_data;
                    skid_err_d  = ext_err;
                    state_d     = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_data_d = skid_data_q;
                    out_err_d  = skid_err_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_imm_extender.sv
// Self-checking bench for imm_extender: vector table, hand sequences, random traffic.
// Expectations follow IMMEXT_BYTE_MODES_EN the same way the design does.
module tb_imm_extender;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm    = '0;
    logic [2:0]       in_mode   = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic [15:0]      xfer_count;

    always #5 clk = ~clk;

    imm_extender #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .xfer_count(xfer_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [OUT_W:0] exp_q[$];   // {err, data} of accepted results, oldest first
    logic [OUT_W:0] got_q[$];
    logic [15:0]    m_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on the mode rules.
    function automatic void ref_ext(input logic [IN_W-1:0] imm, input logic [2:0] mode,
                                    output logic [OUT_W-1:0] d, output logic e);
        longint u, s, b, v;
        u = longint'(imm);
        s = (u >= (longint'(1) << (IN_W-1))) ? u - (longint'(1) << IN_W) : u;
        b = u % 256;
        v = 0;
        e = 1'b0;
        case (mode)
            3'd0: v = s;
            3'd1: v = u;
            3'd2: v = u * (longint'(1) << (OUT_W-IN_W));
            3'd3: v = s * 4;
`ifdef IMMEXT_BYTE_MODES_EN
            3'd4: v = (b >= 128) ? b - 256 : b;
            3'd5: v = b;
`endif
            default: e = 1'b1;
        endcase
        d = v[OUT_W-1:0];
    endfunction

    task automatic cycle();
        logic ix, ox, was_rst, e;
        logic [OUT_W-1:0] d;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        was_rst = rst;
        if (rst) begin
            exp_q.delete();
            m_cnt = '0;
        end else begin
            if (ox) begin
                got_q.push_back({out_err, out_data});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_cnt++;
            end
            if (ix) begin
                ref_ext(in_imm, in_mode, d, e);
                exp_q.push_back({e, d});
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
        if (exp_q.size() > 0)
            chk("out_result", 64'({out_err, out_data}), 64'(exp_q[0]));
        else if (was_rst)
            chk("reset_result", 64'({out_err, out_data}), 64'(0));
    endtask

    task automatic drive(input bit r, input bit v, input logic [IN_W-1:0] imm,
                         input logic [2:0] mode, input bit ordy);
        rst = r; in_valid = v; in_imm = imm; in_mode = mode; out_ready = ordy;
        cycle();
    endtask

    typedef struct {
        logic [IN_W-1:0]  imm;
        logic [2:0]       mode;
        logic [OUT_W-1:0] data;
        logic             err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit sent, acc;
        logic [OUT_W-1:0] seq_exp[3];

        vecs[0] = '{16'h8000, 3'd0, 32'hFFFF8000, 1'b0};
        vecs[1] = '{16'h8000, 3'd1, 32'h00008000, 1'b0};
        vecs[2] = '{16'h1234, 3'd2, 32'h12340000, 1'b0};
        vecs[3] = '{16'hFFFF, 3'd3, 32'hFFFFFFFC, 1'b0};
        vecs[4] = '{16'h7FFF, 3'd0, 32'h00007FFF, 1'b0};
        vecs[5] = '{16'h7FFF, 3'd3, 32'h0001FFFC, 1'b0};
        vecs[6] = '{16'h0080, 3'd7, 32'h00000000, 1'b1};
        vecs[7] = '{16'h00FF, 3'd6, 32'h00000000, 1'b1};
`ifdef IMMEXT_BYTE_MODES_EN
        vecs[8] = '{16'h0080, 3'd4, 32'hFFFFFF80, 1'b0};
        vecs[9] = '{16'hAB80, 3'd5, 32'h00000080, 1'b0};
`else
        vecs[8] = '{16'h0080, 3'd4, 32'h00000000, 1'b1};
        vecs[9] = '{16'hAB80, 3'd5, 32'h00000000, 1'b1};
`endif

        drive(1, 0, '0, '0, 1);
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));

        // Back-to-back vectors: each result must appear one cycle after acceptance.
        foreach (vecs[i]) begin
            drive(0, 1, vecs[i].imm, vecs[i].mode, 1);
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].data));
            chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err));
        end
        drive(0, 0, '0, '0, 1);

        // Stall fills the skid register, then drains in order.
        drive(1, 0, '0, '0, 1);
        drive(0, 1, 16'h0001, 3'd0, 0);
        drive(0, 1, 16'h0002, 3'd0, 0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        got_q.delete();
        sent = 0;
        for (int k = 0; k < 20 && !(sent && exp_q.size() == 0); k++) begin
            acc = !sent && in_ready;
            drive(0, !sent, 16'h0003, 3'd0, 1);
            if (acc) sent = 1;
        end
        seq_exp[0] = 32'h1; seq_exp[1] = 32'h2; seq_exp[2] = 32'h3;
        chk("seq_count", 64'(got_q.size()), 64'(3));
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            chk($sformatf("seq_out%0d", i), 64'(got_q[i]), 64'(seq_exp[i]));
        chk("seq_xfer_count", 64'(xfer_count), 64'(3));

        // Reset from FULL with a nonzero count; handshakes in the reset cycle are dropped.
        drive(1, 0, '0, '0, 1);
        for (int k = 0; k < 50 && m_cnt < 16'd5; k++) drive(0, 1, 16'(k), 3'd0, 1);
        for (int k = 0; k < 10 && exp_q.size() < 2; k++) drive(0, 1, 16'h0009, 3'd1, 0);
        chk("pre_rst_full", 64'(in_ready), 64'(0));
        chk("pre_rst_count", 64'(xfer_count), 64'(5));
        drive(1, 1, 16'h0055, 3'd0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_count", 64'(xfer_count), 64'(0));
        chk("rst_data", 64'({out_err, out_data}), 64'(0));
        drive(0, 1, 16'h8000, 3'd0, 1);
        chk("post_rst_valid", 64'(out_valid), 64'(1));
        chk("post_rst_data", 64'(out_data), 64'(32'hFFFF8000));
        drive(0, 0, '0, '0, 1);

        // Random traffic with occasional reset.
        for (int k = 0; k < 2000; k++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 16'($urandom),
                  3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);

        // Counter wrap.
        drive(1, 0, '0, '0, 1);
        for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) drive(0, 1, 16'(k), 3'd1, 1);
        chk("wrap_pre", 64'(xfer_count), 64'(16'hFFFF));
        for (int k = 0; k < 5 && m_cnt != 16'h0000; k++) drive(0, 1, 16'h0001, 3'd0, 1);
        chk("wrap_post", 64'(xfer_count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
